// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   state_e        arbiter sequencer states (IDLE, ISSUE, RESP, DONE)
//   req_id_e       requester identifiers (REQ_CPU=0, REQ_DMA=1)
//   MMIO_OUT_ADDR  output-register address decoded inside the memory;
//                  benches use it, the arbiter passes it through untouched.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

  localparam logic [31:0] MMIO_OUT_ADDR = 32'hFFFF0000;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports, the memory port and
// the grant indicator around dmem_arbiter.
//   cpu_req/we/addr/wd -> arbiter, cpu_rd/ack <- arbiter (CPU data port)
//   dma_req/we/addr/wd -> arbiter, dma_rd/ack <- arbiter (DMA/loader port)
//   mem_we/addr/wd     <- arbiter, mem_rd -> arbiter (single-port memory)
//   gnt_dma            <- arbiter, owner of current/last transaction
// Modports: slave = arbiter side, master = requesters + memory side.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wd;
  logic [DW-1:0] dma_rd;
  logic          dma_ack;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic          gnt_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    output cpu_rd, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wd,
    output dma_rd, dma_ack,
    output mem_we, mem_addr, mem_wd,
    input  mem_rd,
    output gnt_dma
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  cpu_rd, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wd,
    input  dma_rd, dma_ack,
    input  mem_we, mem_addr, mem_wd,
    output mem_rd,
    input  gnt_dma
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational two-way request picker.
//   cpu_req, dma_req  pending requests
//   prio              requester preferred when both are pending
//   valid             at least one request pending
//   winner            selected requester (meaningful when valid=1)
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic    cpu_req,
  input  logic    dma_req,
  input  req_id_e prio,
  output logic    valid,
  output req_id_e winner
);

  always_comb begin
    valid  = cpu_req | dma_req;
    winner = REQ_CPU;
    if (prio == REQ_DMA) begin
      winner = dma_req ? REQ_DMA : REQ_CPU;
    end else begin
      winner = (cpu_req || !dma_req) ? REQ_CPU : REQ_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data memory (1-cycle
// registered read) between the CPU data port and a DMA/loader port.
// Each transaction: IDLE (sample + latch) -> ISSUE (drive memory one cycle)
// -> RESP (capture mem_rd) -> DONE (1-cycle ack to the winner).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    dmem_arbiter_if.slave (requester ports, memory port, gnt_dma)
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for an alternating priority
// pointer; otherwise the CPU always wins a tie.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  state_e        state_q, state_d;
  req_id_e       gnt_q;
  req_id_e       prio;
  logic          pick_valid;
  req_id_e       pick_winner;

  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wd;

  logic [DW-1:0] cpu_rd_q, dma_rd_q;
  logic          cpu_ack_q, dma_ack_q;

  dmem_arb_pick u_pick (
    .cpu_req (bus.cpu_req),
    .dma_req (bus.dma_req),
    .prio    (prio),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  req_id_e prio_q;

  // Point at whichever requester did not win, so back-to-back ties alternate.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= REQ_CPU;
    end else if (state_q == IDLE && pick_valid) begin
      prio_q <= (pick_winner == REQ_CPU) ? REQ_DMA : REQ_CPU;
    end
  end

  assign prio = prio_q;
`else
  assign prio = REQ_CPU;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= REQ_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wd    <= '0;
      cpu_rd_q  <= '0;
      dma_rd_q  <= '0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && pick_valid) begin
        gnt_q    <= pick_winner;
        lat_we   <= (pick_winner == REQ_DMA) ? bus.dma_we   : bus.cpu_we;
        lat_addr <= (pick_winner == REQ_DMA) ? bus.dma_addr : bus.cpu_addr;
        lat_wd   <= (pick_winner == REQ_DMA) ? bus.dma_wd   : bus.cpu_wd;
      end

      // Only the winner's rd/ack are touched; the other port keeps its value.
      if (state_q == RESP) begin
        if (gnt_q == REQ_DMA) begin
          dma_rd_q  <= bus.mem_rd;
          dma_ack_q <= 1'b1;
        end else begin
          cpu_rd_q  <= bus.mem_rd;
          cpu_ack_q <= 1'b1;
        end
      end

      if (state_q == DONE) begin
        cpu_ack_q <= 1'b0;
        dma_ack_q <= 1'b0;
      end
    end
  end

  // Address/data come straight from the latch, so they hold their last value
  // outside ISSUE; the write strobe is gated by reset so an aborted ISSUE
  // never reaches the memory.
  assign bus.mem_addr = lat_addr;
  assign bus.mem_wd   = lat_wd;
  assign bus.mem_we   = (state_q == ISSUE) & lat_we & ~reset;

  assign bus.cpu_rd   = cpu_rd_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.dma_rd   = dma_rd_q;
  assign bus.dma_ack  = dma_ack_q;
  assign bus.gnt_dma  = (gnt_q == REQ_DMA);

endmodule
